// File: rtl/mux_3_1_if.sv
// mux_3_1_if: signal bundle for the mux_3_1 selector.
//   WIDTH    : data width of a/b/c/y/y_q
//   a, b, c  : data inputs (codes 00, 01, 10/11)
//   sel1     : select MSB, sel2 : select LSB
//   clr_err  : synchronous clear of the sticky select-error flag
//   y        : combinational result, y_q : registered result
//   sel_err  : registered reserved-code flag
// master drives data/select/clear; slave (the mux) drives the results.
interface mux_3_1_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             sel1;
  logic             sel2;
  logic             clr_err;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             sel_err;

  modport master (
    output a, b, c, sel1, sel2, clr_err,
    input  y, y_q, sel_err
  );

  modport slave (
    input  a, b, c, sel1, sel2, clr_err,
    output y, y_q, sel_err
  );
endinterface

// File: rtl/mux_3_1.sv
// mux_3_1: three-input WIDTH-bit selector with combinational and
// registered outputs plus a reserved-select-code flag.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (clears y_q and sel_err)
//   bus     : mux_3_1_if.slave carrying a, b, c, sel1, sel2, clr_err in
//             and y, y_q, sel_err out
// Select code {sel1, sel2}: 00 -> a, 01 -> b, 10 -> c, 11 (reserved) -> c.
// Optional feature macro: MUX_3_1_STICKY_ERR_EN
//   defined   : sel_err is sticky; set by any sampled code 11, cleared by
//               clr_err without a concurrent code 11 (set wins)
//   undefined : sel_err is the registered (sel1 & sel2); clr_err ignored
module mux_3_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_3_1_if.slave  bus
);

  logic [1:0]       code;
  logic             code_rsv;
  logic [WIDTH-1:0] y_mux;
  logic [WIDTH-1:0] y_reg;
  logic             err_reg;
  logic             err_nxt;

  assign code     = {bus.sel1, bus.sel2};
  assign code_rsv = bus.sel1 & bus.sel2;

  // Both 10 and 11 route c; an unknown select yields X in simulation.
  always_comb begin
    y_mux = 'x;
    case (code)
      2'b00:   y_mux = bus.a;
      2'b01:   y_mux = bus.b;
      2'b10,
      2'b11:   y_mux = bus.c;
      default: y_mux = 'x;
    endcase
  end

`ifdef MUX_3_1_STICKY_ERR_EN
  // Set has priority over clear when both are sampled together.
  always_comb begin
    err_nxt = code_rsv | (err_reg & ~bus.clr_err);
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;

  always_comb begin
    err_nxt = code_rsv;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      y_reg   <= y_mux;
      err_reg <= err_nxt;
    end
  end

  assign bus.y       = y_mux;
  assign bus.y_q     = y_reg;
  assign bus.sel_err = err_reg;

endmodule

// File: tb/tb_mux_3_1.sv
// tb_mux_3_1: directed-vector bench for mux_3_1 at WIDTH=1 and WIDTH=8.
// Works in both builds; sticky-flag expectations follow
// MUX_3_1_STICKY_ERR_EN.
module tb_mux_3_1;

`ifdef MUX_3_1_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst;
  int unsigned vectors;
  int unsigned miscompares;

  mux_3_1_if #(.WIDTH(1)) b1 ();
  mux_3_1_if #(.WIDTH(8)) b8 ();

  mux_3_1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mux_3_1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply select/clear on w1 at the falling edge, then sample after the rise.
  task automatic step1(input logic [1:0] sel, input logic clr);
    @(negedge clk);
    b1.sel1    = sel[1];
    b1.sel2    = sel[0];
    b1.clr_err = clr;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    b1.a = '0; b1.b = '0; b1.c = '0; b1.sel1 = 0; b1.sel2 = 0; b1.clr_err = 0;
    b8.a = '0; b8.b = '0; b8.c = '0; b8.sel1 = 0; b8.sel2 = 0; b8.clr_err = 0;
    #1;
    chk("rst_yq1",  32'(b1.y_q),    0);
    chk("rst_err1", 32'(b1.sel_err), 0);
    chk("rst_yq8",  32'(b8.y_q),    0);
    chk("rst_err8", 32'(b8.sel_err), 0);

    // Combinational sweep, WIDTH=1
    b1.a = 1; b1.b = 0; b1.c = 0; b1.sel1 = 0; b1.sel2 = 0; #5;
    chk("sweep00", 32'(b1.y), 1);
    b1.a = 0; b1.b = 1; b1.c = 0; b1.sel1 = 0; b1.sel2 = 1; #5;
    chk("sweep01", 32'(b1.y), 1);
    b1.a = 0; b1.b = 0; b1.c = 1; b1.sel1 = 1; b1.sel2 = 0; #5;
    chk("sweep10", 32'(b1.y), 1);
    b1.a = 1; b1.b = 1; b1.c = 1; b1.sel1 = 1; b1.sel2 = 1; #5;
    chk("sweep11", 32'(b1.y), 1);
    b1.a = 0; b1.b = 0; b1.c = 0; #5;
    chk("sweep11_c0", 32'(b1.y), 0);

    // Reserved-code routing, WIDTH=8
    b8.a = 8'h11; b8.b = 8'h22; b8.c = 8'h33; b8.sel1 = 1; b8.sel2 = 1; #5;
    chk("w8_code11", 32'(b8.y), 32'h33);
    b8.sel1 = 0; b8.sel2 = 0; #5;
    chk("w8_code00", 32'(b8.y), 32'h11);
    b8.sel1 = 1; b8.sel2 = 0; #5;
    chk("w8_code10", 32'(b8.y), 32'h33);
    b8.sel1 = 0; b8.sel2 = 0; #5;

    // Edges have passed with rst high: registers must still be clear.
    chk("rst_hold_yq8",  32'(b8.y_q),    0);
    chk("rst_hold_err1", 32'(b1.sel_err), 0);

    // Release reset; first edge loads current y.
    @(negedge clk);
    rst = 1'b0;
    b1.a = 1; b1.b = 0; b1.c = 0; b1.sel1 = 0; b1.sel2 = 0;
    tick();
    chk("first_yq8", 32'(b8.y_q), 32'h11);
    chk("first_yq1", 32'(b1.y_q), 1);
    chk("first_err1", 32'(b1.sel_err), 0);

    // Registered path: code 00 -> 01 between edges.
    @(negedge clk);
    b1.sel2 = 1;
    b8.sel2 = 1;
    #1;
    chk("reg_y1_now",   32'(b1.y),   0);
    chk("reg_yq1_hold", 32'(b1.y_q), 1);
    chk("reg_y8_now",   32'(b8.y),   32'h22);
    chk("reg_yq8_hold", 32'(b8.y_q), 32'h11);
    tick();
    chk("reg_yq1_load", 32'(b1.y_q), 0);
    chk("reg_yq8_load", 32'(b8.y_q), 32'h22);

    // Error flag sequence on w1 (c=1 so code 11 loads y_q=1).
    b1.c = 1;
    step1(2'b11, 1'b0);
    chk("err_set", 32'(b1.sel_err), 1);
    step1(2'b00, 1'b0);
    chk("err_after1", 32'(b1.sel_err), 32'(STICKY));
    step1(2'b00, 1'b0);
    chk("err_after2", 32'(b1.sel_err), 32'(STICKY));
    step1(2'b00, 1'b1);
    chk("err_clr", 32'(b1.sel_err), 0);
    step1(2'b11, 1'b1);
    chk("err_set_wins", 32'(b1.sel_err), 1);
    step1(2'b00, 1'b1);
    chk("err_clr2", 32'(b1.sel_err), 0);
    step1(2'b11, 1'b0);
    chk("err_set2", 32'(b1.sel_err), 1);
    chk("yq_c", 32'(b1.y_q), 1);
    chk("w8_err_quiet", 32'(b8.sel_err), 0);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_yq1",  32'(b1.y_q),    0);
    chk("arst_err1", 32'(b1.sel_err), 0);
    chk("arst_yq8",  32'(b8.y_q),    0);
    b1.clr_err = 0; b1.sel1 = 0; b1.sel2 = 0; b1.a = 0; #1;
    chk("arst_y_a0", 32'(b1.y), 0);
    b1.a = 1; #1;
    chk("arst_y_a1", 32'(b1.y), 1);
    tick();
    chk("arst_hold_yq1", 32'(b1.y_q), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_arst_yq1",  32'(b1.y_q),    1);
    chk("post_arst_err1", 32'(b1.sel_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_3_1.md
# mux_3_1

Three-input, WIDTH-bit selector. Two select bits choose one of `a`/`b`/`c`. The block drives both a combinational result and a registered copy of it. It also flags use of the reserved select code. It sits in datapath steering logic where the selected value is needed in the same cycle, and a clean registered copy is needed in the next cycle.

## Interface
- `WIDTH`, default 1: bit width of each data input and of each data output.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a` input WIDTH: data input, selected by code 00.
- `b` input WIDTH: data input, selected by code 01.
- `c` input WIDTH: data input, selected by code 10, and also by reserved code 11.
- `sel1` input 1: select MSB.
- `sel2` input 1: select LSB.
- `clr_err` input 1: synchronous clear of the sticky error flag.
- `y` output WIDTH: combinational mux result.
- `y_q` output WIDTH: `y` registered on `clk`.
- `sel_err` output 1: registered flag, set when the select code was 11.

## Operation
- The select code is `{sel1, sel2}`.
- Combinational output `y`:
  - 00 → `a`
  - 01 → `b`
  - 10 → `c`
  - 11 → `c` (reserved code; selecting `c` is a fixed requirement)
- `y` is purely combinational and is not affected by `rst` or `clk`.
- `y` changes within the same delta as any input change.
- `y_q` loads `y` on every rising `clk`. There is no enable.
- `sel_err` behaviour depends on `MUX_3_1_STICKY_ERR_EN` (see Configuration).
- `clr_err` has effect only in sticky mode. It is ignored otherwise.
- X or Z on a select bit: `y` is don't-care in synthesis. Simulation models propagate X.
- Bit-for-bit pass-through; no arithmetic. All data paths are exactly WIDTH bits.

## Timing
- `y`: zero-cycle latency (combinational).
- `y_q`: one-cycle latency; reflects `y` sampled at the preceding rising edge.
- `sel_err`: one-cycle latency after a code-11 sample.
- Reset values: `y_q` = 0 and `sel_err` = 0, taken immediately on `rst` assertion with no clock needed.
- While `rst` is high, registered outputs hold 0. `y` keeps tracking the inputs.
- On the first rising edge after `rst` deasserts, `y_q` loads the current `y`.
- Reset mid-operation: `rst` overrides any pending load or clear.
- Simultaneous code 11 and `clr_err` in sticky mode: set wins, so `sel_err` = 1.

## Configuration
- Macro: `MUX_3_1_STICKY_ERR_EN`.
- Defined (sticky mode):
  - `sel_err` sets on any sampled code 11.
  - It holds until `clr_err` = 1 is sampled without a concurrent code 11, or until `rst`.
- Undefined (per-cycle mode):
  - `sel_err` is the registered value of `(sel1 & sel2)` every cycle.
  - `clr_err` is ignored.
- `y` and `y_q` behaviour are identical in both builds.

## Test plan
- Combinational select sweep, WIDTH=1. Each step is 5 time units and must produce the stated `y` with no clock:
  - `a=1 b=0 c=0`, code 00 → `y=1`
  - `a=0 b=1 c=0`, code 01 → `y=1`
  - `a=0 b=0 c=1`, code 10 → `y=1`
  - `a=1 b=1 c=1`, code 11 → `y=1`
- Reserved-code routing, WIDTH=8: `a=8'h11 b=8'h22 c=8'h33`, code 11 → `y=8'h33`. Code 00 → `y=8'h11`.
- Registered path: with `rst` low, change code from 00 to 01 (`a=1 b=0`) between edges. `y_q` stays 1 until the next rising edge, then becomes 0.
- Async reset: assert `rst` between clock edges while `y_q=1` and `sel_err=1`. Both go to 0 immediately, and `y` keeps following the inputs.
- Sticky flag (macro defined):
  - Code 11 for one cycle, then 00 → `sel_err` rises one cycle later and stays 1.
  - `clr_err=1` for one cycle → `sel_err=0` on the next edge.
  - Code 11 with `clr_err=1` at the same time → `sel_err=1`.
- Per-cycle flag (macro undefined): code 11 for one cycle, then 00 → `sel_err` is 1 for exactly one cycle. `clr_err` has no effect.
